// File: rtl/branch_pc_control_pkg.sv
// Shared types for the program counter / relative branch sequencer.
// State encoding, condition-select codes and the reset vector default.
package branch_pc_control_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'hFFFC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD_LO = 2'd1,
    ST_FIX_HI = 2'd2
  } state_t;

  // branch_op[7:6] selects the tested flag
  localparam logic [1:0] COND_N = 2'b00;
  localparam logic [1:0] COND_V = 2'b01;
  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] COND_Z = 2'b11;

  // High byte of a 16-bit value
  function automatic logic [7:0] hi_byte(
    input logic [15:0] v
  );
    return v[15:8];
  endfunction

  // Low byte of a 16-bit value
  function automatic logic [7:0] lo_byte(
    input logic [15:0] v
  );
    return v[7:0];
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational 6502 branch condition evaluation.
// Ports: cond_code = branch_op[7:5], flag_n/v/c/z in; taken out.
module branch_cond_eval
  import branch_pc_control_pkg::*;
(
  input  logic [2:0] cond_code,
  input  logic       flag_n,
  input  logic       flag_v,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       taken
);

  logic [1:0] sel;
  logic       want;
  logic       flag;

  assign sel  = cond_code[2:1];
  assign want = cond_code[0];

  always_comb begin
    flag = 1'b0;
    unique case (1'b1)
      (sel == COND_N): flag = flag_n;
      (sel == COND_V): flag = flag_v;
      (sel == COND_C): flag = flag_c;
      (sel == COND_Z): flag = flag_z;
      default:         flag = 1'b0;
    endcase
  end

  assign taken = (flag == want);

endmodule

// File: rtl/branch_pc_control.sv
// Program counter owner and 6502 relative-branch sequencer.
// Ports: clk, rst, pc_inc, pc_load, load_addr, branch_start, branch_op,
//   flag_n/v/c/z, pcl_branch, pch_branch in;
//   pcl, pch, busy, branch_taken, page_cross, done out.
module branch_pc_control
  import branch_pc_control_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [15:0] load_addr,
  input  logic        branch_start,
  input  logic [7:0]  branch_op,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic [7:0]  pcl_branch,
  input  logic [7:0]  pch_branch,
  output logic [7:0]  pcl,
  output logic [7:0]  pch,
  output logic        busy,
  output logic        branch_taken,
  output logic        page_cross,
  output logic        done
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] pc_plus1;
  logic [7:0]  pch_save;
  logic [7:0]  pch_save_nxt;
  logic        taken_nxt;
  logic        cross_nxt;
  logic        done_nxt;
  logic        cond_taken;
  logic        hi_differs;

  // Low opcode bits only identify the instruction class
  logic        unused_op_bits;
  assign unused_op_bits = ^branch_op[4:0];

  branch_cond_eval u_cond (
    .cond_code (branch_op[7:5]),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .taken     (cond_taken)
  );

  assign pc_plus1   = pc + 16'd1;
  assign hi_differs = (pch_branch != hi_byte(pc));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (branch_start && cond_taken) begin
          state_nxt = ST_ADD_LO;
        end
      end
      ST_ADD_LO: begin
        if (hi_differs) begin
          state_nxt = ST_FIX_HI;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FIX_HI: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_nxt       = pc;
    pch_save_nxt = pch_save;
    taken_nxt    = branch_taken;
    cross_nxt    = page_cross;
    done_nxt     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (branch_start) begin
          // Step past the offset byte
          pc_nxt    = pc_plus1;
          taken_nxt = cond_taken;
          cross_nxt = 1'b0;
          done_nxt  = !cond_taken;
        end else if (pc_load) begin
          pc_nxt = load_addr;
        end else if (pc_inc) begin
          pc_nxt = pc_plus1;
        end
      end
      ST_ADD_LO: begin
        pc_nxt = {hi_byte(pc), pcl_branch};
        if (hi_differs) begin
          // Adder outputs go stale next cycle; keep the high byte
          pch_save_nxt = pch_branch;
          cross_nxt    = 1'b1;
        end else begin
          done_nxt = 1'b1;
        end
      end
      ST_FIX_HI: begin
        pc_nxt   = {pch_save, lo_byte(pc)};
        done_nxt = 1'b1;
      end
      default: begin
        pc_nxt = pc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      pch_save     <= 8'h00;
      branch_taken <= 1'b0;
      page_cross   <= 1'b0;
      done         <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      pch_save     <= pch_save_nxt;
      branch_taken <= taken_nxt;
      page_cross   <= cross_nxt;
      done         <= done_nxt;
    end
  end

  // Outputs
  always_comb begin
    pcl  = lo_byte(pc);
    pch  = hi_byte(pc);
    busy = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_branch_pc_control.sv
// Self-checking bench for branch_pc_control.
// Directed and random branches against a behavioural PC model.
module tb_branch_pc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] load_addr;
  logic        branch_start;
  logic [7:0]  branch_op;
  logic        flag_n;
  logic        flag_v;
  logic        flag_c;
  logic        flag_z;
  logic [7:0]  pcl_branch;
  logic [7:0]  pch_branch;
  logic [7:0]  pcl;
  logic [7:0]  pch;
  logic        busy;
  logic        branch_taken;
  logic        page_cross;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  branch_pc_control dut (
    .clk          (clk),
    .rst          (rst),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .load_addr    (load_addr),
    .branch_start (branch_start),
    .branch_op    (branch_op),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .pcl_branch   (pcl_branch),
    .pch_branch   (pch_branch),
    .pcl          (pcl),
    .pch          (pch),
    .busy         (busy),
    .branch_taken (branch_taken),
    .page_cross   (page_cross),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: flag picked by op[7:6] in N,V,C,Z order must equal op[5]
  function automatic bit ref_taken(input logic [7:0] op,
                                   input logic [3:0] nvcz);
    bit fl [4];
    int idx;
    fl[0] = nvcz[3];
    fl[1] = nvcz[2];
    fl[2] = nvcz[1];
    fl[3] = nvcz[0];
    idx = int'(op[7:6]);
    return fl[idx] == op[5];
  endfunction

  function automatic logic [15:0] cur_pc();
    return {pch, pcl};
  endfunction

  task automatic quiet();
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    branch_start = 1'b0;
  endtask

  task automatic noise();
    pc_inc       = 1'($urandom_range(0, 1));
    pc_load      = 1'($urandom_range(0, 1));
    branch_start = 1'($urandom_range(0, 1));
    load_addr    = 16'($urandom);
  endtask

  task automatic set_pc(input logic [15:0] a);
    @(negedge clk);
    quiet();
    pc_load   = 1'b1;
    load_addr = a;
    @(negedge clk);
    quiet();
    chk("load", cur_pc(), a);
  endtask

  // One full branch; adder outputs driven as a real adder would
  task automatic run_branch(input logic [15:0] spc, input logic [7:0] op,
                            input logic [3:0] nvcz, input logic [7:0] off);
    logic [15:0] pc1;
    logic [15:0] tgt;
    bit          tk;
    bit          cr;
    set_pc(spc);
    pc1 = spc + 16'd1;
    tgt = pc1 + {{8{off[7]}}, off};
    tk  = ref_taken(op, nvcz);
    cr  = tk && (tgt[15:8] != pc1[15:8]);
    branch_op = op;
    {flag_n, flag_v, flag_c, flag_z} = nvcz;
    branch_start = 1'b1;
    pc_inc       = 1'($urandom_range(0, 1));
    pc_load      = 1'($urandom_range(0, 1));
    load_addr    = 16'($urandom);
    pcl_branch   = 8'($urandom);
    pch_branch   = 8'($urandom);
    @(negedge clk);
    quiet();
    chk("start_pc", cur_pc(), pc1);
    chk("start_taken", 16'(branch_taken), 16'(tk));
    chk("start_cross", 16'(page_cross), 16'd0);
    chk("start_busy", 16'(busy), 16'(tk));
    chk("start_done", 16'(done), 16'(!tk));
    if (tk) begin
      pcl_branch = tgt[7:0];
      pch_branch = tgt[15:8];
      noise();
      @(negedge clk);
      pch_branch = tgt[15:8] ^ 8'($urandom_range(1, 255));
      pcl_branch = 8'($urandom);
      chk("addlo_pc", cur_pc(), cr ? {pc1[15:8], tgt[7:0]} : tgt);
      chk("addlo_busy", 16'(busy), 16'(cr));
      chk("addlo_done", 16'(done), 16'(!cr));
      chk("addlo_cross", 16'(page_cross), 16'(cr));
      if (cr) begin
        noise();
        @(negedge clk);
        chk("fixhi_pc", cur_pc(), tgt);
        chk("fixhi_busy", 16'(busy), 16'd0);
        chk("fixhi_done", 16'(done), 16'd1);
      end
    end
    quiet();
    @(negedge clk);
    chk("done_clear", 16'(done), 16'd0);
    chk("pc_hold", cur_pc(), tk ? tgt : pc1);
  endtask

  initial begin
    logic [2:0] cc;
    rst = 1'b1;
    quiet();
    load_addr  = 16'h0;
    branch_op  = 8'h0;
    {flag_n, flag_v, flag_c, flag_z} = 4'h0;
    pcl_branch = 8'h0;
    pch_branch = 8'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", cur_pc(), 16'hFFFC);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_taken", 16'(branch_taken), 16'd0);
    chk("rst_cross", 16'(page_cross), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    rst = 1'b0;

    // BEQ not taken, BNE same page, BCS forward cross, BPL backward cross
    run_branch(16'h1000, 8'hF0, 4'b0000, 8'h10);
    run_branch(16'h1000, 8'hD0, 4'b0000, 8'h10);
    run_branch(16'h10F0, 8'hB0, 4'b0010, 8'h20);
    run_branch(16'h1000, 8'h10, 4'b0000, 8'hF0);
    // Cross over the top of memory
    run_branch(16'hFFF0, 8'h30, 4'b1000, 8'h7F);

    // Wrap on increment
    set_pc(16'hFFFF);
    pc_inc = 1'b1;
    @(negedge clk);
    quiet();
    chk("inc_wrap", cur_pc(), 16'h0000);

    // Load beats increment
    pc_load   = 1'b1;
    pc_inc    = 1'b1;
    load_addr = 16'h8000;
    @(negedge clk);
    quiet();
    chk("load_prio", cur_pc(), 16'h8000);

    // Idle with nothing asserted holds
    @(negedge clk);
    chk("idle_hold", cur_pc(), 16'h8000);

    // Random branches
    for (int i = 0; i < 60; i++) begin
      cc = 3'($urandom_range(0, 7));
      run_branch(16'($urandom), {cc, 5'b10000}, 4'($urandom),
                 8'($urandom));
    end

    // Reset during FIX_HI
    set_pc(16'h10F0);
    branch_op = 8'hB0;
    {flag_n, flag_v, flag_c, flag_z} = 4'b0010;
    branch_start = 1'b1;
    @(negedge clk);
    quiet();
    pcl_branch = 8'h11;
    pch_branch = 8'h11;
    @(negedge clk);
    chk("pre_rst_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_pc", cur_pc(), 16'hFFFC);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_done", 16'(done), 16'd0);
    chk("mid_rst_cross", 16'(page_cross), 16'd0);
    chk("mid_rst_taken", 16'(branch_taken), 16'd0);
    @(negedge clk);
    chk("post_rst_pc", cur_pc(), 16'hFFFC);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_pc_control.md
Name: branch_pc_control

Overview:
- Owns the 16-bit program counter and sequences 6502 relative branches (BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ) around the combinational branch-target adder.
- Drives pcl/pch into the adder and consumes pcl_branch/pch_branch back from it.
- Evaluates the branch condition and applies the low-byte then high-byte PC update with correct 6502 cycle counts: 2 cycles not taken, 3 taken, 4 taken with page cross.
- Also services plain PC increment and absolute load from the control unit.

Parameters:
- RESET_PC, 16'hFFFC, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_inc  in  1  PC <= PC+1 this edge (idle only).
- pc_load  in  1  PC <= load_addr this edge (idle only).
- load_addr  in  16  absolute load value.
- branch_start  in  1  branch opcode decoded; memory data bus currently presents the offset byte at PC.
- branch_op  in  8  branch opcode (form xxy10000).
- flag_n, flag_v, flag_c, flag_z  in  1 each  status flags.
- pcl_branch  in  8  adder result low byte.
- pch_branch  in  8  adder result high byte.
- pcl  out  8  PC low byte (to adder and address mux).
- pch  out  8  PC high byte.
- busy  out  1  branch sequence in progress.
- branch_taken  out  1  registered condition result of the last branch.
- page_cross  out  1  registered; last taken branch crossed a page.
- done  out  1  one-cycle pulse at branch completion.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - PC = RESET_PC; state = IDLE.
  - busy = 0, branch_taken = 0, page_cross = 0, done = 0.
  - pch_save is cleared.
  - Reset overrides every other input, including mid-sequence.
- Condition: flag select by branch_op[7:6] (00 N, 01 V, 10 C, 11 Z); taken = (selected flag == branch_op[5]).
- The adder registers its offset from the data bus every edge. Its outputs are therefore valid only in the cycle immediately after the start edge.
- States: IDLE, ADD_LO, FIX_HI. busy = (state != IDLE).
- IDLE:
  - On branch_start: PC <= PC+1 (past the offset byte); branch_taken <= taken; page_cross <= 0.
    - Taken: go to ADD_LO.
    - Not taken: stay IDLE and pulse done next cycle.
  - Otherwise, if pc_load: PC <= load_addr.
  - Otherwise, if pc_inc: PC <= PC+1.
  - Priority: branch_start > pc_load > pc_inc. Simultaneous branch_start and pc_inc increments PC once only.
- ADD_LO:
  - pcl <= pcl_branch.
  - If pch_branch == pch: go to IDLE and pulse done.
  - Else: pch_save <= pch_branch, page_cross <= 1, go to FIX_HI.
- FIX_HI:
  - pch <= pch_save. The live pch_branch is stale here and must not be used.
  - Go to IDLE and pulse done.
- While busy, pc_inc, pc_load and branch_start are ignored.
- done is high for exactly one cycle, in the cycle after the final update edge.
- Wrap-around:
  - PC+1 wraps 16'hFFFF -> 16'h0000.
  - A page cross across 0xFFxx/0x00xx follows whatever pch_branch reports.
- Cycle count from the opcode fetch: 2 not taken, 3 taken, 4 taken with page cross. The block contributes 1, 2 or 3 edges respectively.

Decomposition:
- Shared package: state encoding (IDLE/ADD_LO/FIX_HI), condition-select codes, RESET_PC default.
- Sub-module branch_cond_eval: combinational opcode+flags -> taken.
- The FSM and PC register stay in the top.
- The branch-target adder stays external and is instantiated alongside in the CPU top.

Test Plan:
- Not taken: PC=0x1000, BEQ (0xF0), Z=0, offset 0x10 -> after 1 edge PC=0x1001, branch_taken=0, done pulses next cycle, busy never 1.
- Taken, same page: PC=0x1000, BNE (0xD0), Z=0, offset 0x10 -> PC=0x1001, then 0x1011; page_cross=0; done after 2nd edge.
- Forward page cross: PC=0x10F0, BCS (0xB0), C=1, offset 0x20 -> PC 0x10F1, 0x1011, 0x1111; page_cross=1; done after 3rd edge.
- Backward page cross: PC=0x1000, BPL (0x10), N=0, offset 0xF0 -> PC 0x1001, 0x10F1, 0x0FF1; page_cross=1. Bench drives garbage on pch_branch during FIX_HI to prove pch_save is used.
- Priority and wrap: PC=0xFFFF with pc_inc=1 -> 0x0000. In IDLE, pc_load=1, pc_inc=1, load_addr=0x8000 -> 0x8000. pc_inc asserted while busy -> no effect.
- Reset mid-sequence: rst=1 in FIX_HI -> next cycle PC=0xFFFC, busy=0, done=0, page_cross=0, branch_taken=0.
